// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit.
// Memory bus bundles, tracker entry layout, byte-lane and counter helpers.
package dmem_lsu_pkg;

  localparam int tag_max_lp = 16;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  // Tag is stored at its maximum width; the LSU uses the low bits.
  typedef struct packed {
    logic [tag_max_lp-1:0] tag;
    logic                  wen;
    logic                  byte_op;
    logic [1:0]            lane;
  } lsu_entry_s;

  function automatic logic [31:0] lane_extract(
    input logic [31:0] w,
    input logic [1:0]  lane
  );
    return {24'b0, w[8*lane +: 8]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response bundle of the LSU.
// slave: LSU side; master: core side.
interface dmem_lsu_if #(
  parameter int tag_width_p = 5
);
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic                   req_wen_i;
  logic                   req_byte_i;
  logic [31:0]            req_addr_i;
  logic [31:0]            req_data_i;
  logic [tag_width_p-1:0] req_tag_i;
  logic                   resp_valid_o;
  logic [31:0]            resp_data_o;
  logic [tag_width_p-1:0] resp_tag_o;
  logic                   resp_is_load_o;
  logic                   resp_yumi_i;

  modport slave (
    input  req_valid_i, req_wen_i, req_byte_i,
    input  req_addr_i, req_data_i, req_tag_i,
    input  resp_yumi_i,
    output req_ready_o, resp_valid_o, resp_data_o,
    output resp_tag_o, resp_is_load_o
  );

  modport master (
    output req_valid_i, req_wen_i, req_byte_i,
    output req_addr_i, req_data_i, req_tag_i,
    output resp_yumi_i,
    input  req_ready_o, resp_valid_o, resp_data_o,
    input  resp_tag_o, resp_is_load_o
  );
endinterface

// File: rtl/lsu_tag_fifo.sv
// In-order tracker of memory-acked requests awaiting response.
// push_i/data_i in, pop_i/data_o out, full_o/empty_o/count_o status.
module lsu_tag_fifo #(
  parameter  int width_p  = 8,
  parameter  int depth_p  = 4,
  localparam int ptr_w_lp = $clog2(depth_p),
  localparam int cnt_w_lp = $clog2(depth_p+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic [width_p-1:0]  data_i,
  input  logic                pop_i,
  output logic [width_p-1:0]  data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_q [depth_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + ptr_w_lp'(1);
    if (pop_i)  rptr_d = rptr_q + ptr_w_lp'(1);
    unique case (1'b1)
      push_i && !pop_i: cnt_d = cnt_q + cnt_w_lp'(1);
      pop_i && !push_i: cnt_d = cnt_q - cnt_w_lp'(1);
      default:          cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == cnt_w_lp'(depth_p));

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one-entry issue register toward memory plus an
// in-order tag tracker that matches memory responses to requests.
// Ports: core (dmem_lsu_if.slave), to_mem_o/mem_addr_o, from_mem_i,
// outstanding_o, idle_o, err_o, loads_o, stores_o.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter  int depth_p     = 4,
  parameter  int tag_width_p = 5,
  localparam int cnt_w_lp    = $clog2(depth_p+1)
) (
  input  logic                clk,
  input  logic                reset,
  dmem_lsu_if.slave           core,
  output mem_in_s             to_mem_o,
  output logic [31:0]         mem_addr_o,
  input  mem_out_s            from_mem_i,
  output logic [cnt_w_lp-1:0] outstanding_o,
  output logic                idle_o,
  output logic                err_o,
  output logic [15:0]         loads_o,
  output logic [15:0]         stores_o
);

  logic                   iss_v_q, iss_v_d;
  logic                   iss_wen_q, iss_wen_d;
  logic                   iss_byte_q, iss_byte_d;
  logic [31:0]            iss_addr_q, iss_addr_d;
  logic [31:0]            iss_data_q, iss_data_d;
  logic [tag_width_p-1:0] iss_tag_q, iss_tag_d;
  logic                   err_q, err_d;
  logic [15:0]            loads_q, loads_d;
  logic [15:0]            stores_q, stores_d;

  logic [cnt_w_lp-1:0] count;
  logic [cnt_w_lp:0]   occ_sum;
  logic                empty, full;
  logic                accept, push, pop, drain;
  lsu_entry_s          push_e, head_e;

  assign occ_sum = {1'b0, count} + (cnt_w_lp+1)'(iss_v_q);
  assign core.req_ready_o =
    !iss_v_q && (occ_sum < (cnt_w_lp+1)'(depth_p));
  assign accept = core.req_valid_i && core.req_ready_o;
  assign push   = from_mem_i.yumi && iss_v_q;

  assign push_e.tag     = tag_max_lp'(iss_tag_q);
  assign push_e.wen     = iss_wen_q;
  assign push_e.byte_op = iss_byte_q;
  assign push_e.lane    = iss_addr_q[1:0];

  lsu_tag_fifo #(
    .width_p($bits(lsu_entry_s)),
    .depth_p(depth_p)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .data_i (push_e),
    .pop_i  (pop),
    .data_o (head_e),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  assign core.resp_valid_o   = from_mem_i.valid && !empty;
  assign core.resp_tag_o     = head_e.tag[tag_width_p-1:0];
  assign core.resp_is_load_o = !head_e.wen;
  assign pop   = core.resp_yumi_i && core.resp_valid_o;
  // Unsolicited read data is consumed so memory is not stalled.
  assign drain = from_mem_i.valid && empty;

  always_comb begin
    core.resp_data_o = from_mem_i.read_data;
    unique case (1'b1)
      head_e.wen:
        core.resp_data_o = '0;
      !head_e.wen && head_e.byte_op:
        core.resp_data_o =
          lane_extract(from_mem_i.read_data, head_e.lane);
      default:
        core.resp_data_o = from_mem_i.read_data;
    endcase
  end

  always_comb begin
    iss_v_d    = iss_v_q;
    iss_wen_d  = iss_wen_q;
    iss_byte_d = iss_byte_q;
    iss_addr_d = iss_addr_q;
    iss_data_d = iss_data_q;
    iss_tag_d  = iss_tag_q;
    err_d      = err_q;
    loads_d    = loads_q;
    stores_d   = stores_q;
    if (accept) begin
      iss_v_d    = 1'b1;
      iss_wen_d  = core.req_wen_i;
      iss_byte_d = core.req_byte_i;
      iss_addr_d = core.req_addr_i;
      iss_data_d = core.req_data_i;
      iss_tag_d  = core.req_tag_i;
    end else if (push) begin
      iss_v_d = 1'b0;
    end
    if (drain || (from_mem_i.yumi && !iss_v_q)) err_d = 1'b1;
    if (pop && head_e.wen)  stores_d = sat_inc(stores_q);
    if (pop && !head_e.wen) loads_d  = sat_inc(loads_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_v_q    <= 1'b0;
      iss_wen_q  <= 1'b0;
      iss_byte_q <= 1'b0;
      iss_addr_q <= '0;
      iss_data_q <= '0;
      iss_tag_q  <= '0;
      err_q      <= 1'b0;
      loads_q    <= '0;
      stores_q   <= '0;
    end else begin
      iss_v_q    <= iss_v_d;
      iss_wen_q  <= iss_wen_d;
      iss_byte_q <= iss_byte_d;
      iss_addr_q <= iss_addr_d;
      iss_data_q <= iss_data_d;
      iss_tag_q  <= iss_tag_d;
      err_q      <= err_d;
      loads_q    <= loads_d;
      stores_q   <= stores_d;
    end
  end

  assign to_mem_o.write_data    = iss_data_q;
  assign to_mem_o.valid         = iss_v_q;
  assign to_mem_o.wen           = iss_wen_q;
  assign to_mem_o.byte_not_word = iss_byte_q;
  assign to_mem_o.yumi          = pop || drain;
  assign mem_addr_o             = iss_addr_q;

  assign outstanding_o = count;
  assign idle_o        = !iss_v_q && (count == '0);
  assign err_o         = err_q;
  assign loads_o       = loads_q;
  assign stores_o      = stores_q;

  logic unused_full;
  assign unused_full = full;

endmodule
